// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and types for the 32-bit single-cycle processor
package cpu_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/register_file.sv
// register_file: 32x32 register file, two combinational read ports, one clocked write port, x0 hardwired to zero
module register_file
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  reg_idx_t read_register1,
  input  reg_idx_t read_register2,
  input  reg_idx_t write_register,
  input  logic     write_enable,
  input  word_t    write_data,
  output word_t    read_data1,
  output word_t    read_data2
);
  word_t r_regs [NUM_REGS];
  logic  w_we;
  assign w_we = write_enable && (write_register != '0);
  // clear every register on reset (wins over a same-cycle write), otherwise commit the write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[write_register] <= write_data;
    end
  end
  // reads see stored state only, so a same-cycle write is visible after the edge
  assign read_data1 = (read_register1 == '0) ? '0 : r_regs[read_register1];
  assign read_data2 = (read_register2 == '0) ? '0 : r_regs[read_register2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector table, random traffic against an array model, and reset corner sequences
module tb_register_file;
  import cpu_pkg::*;
  logic     clk = 1'b0;
  logic     rst_n = 1'b1;
  reg_idx_t rr1 = '0, rr2 = '0, wr = '0;
  logic     we = 1'b0;
  word_t    wd = '0;
  word_t    rd1, rd2;
  int       total = 0;
  int       fails = 0;
  word_t    m [32];

  typedef struct {
    logic     we;
    reg_idx_t wr;
    word_t    wd;
    reg_idx_t rr1;
    reg_idx_t rr2;
    word_t    exp1;
    word_t    exp2;
  } vec_t;
  vec_t vt [11];

  register_file dut (
    .clk(clk), .rst_n(rst_n),
    .read_register1(rr1), .read_register2(rr2),
    .write_register(wr), .write_enable(we), .write_data(wd),
    .read_data1(rd1), .read_data2(rd2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t model_rd(input reg_idx_t a);
    return (a == 0) ? 32'h0 : m[a];
  endfunction

  task automatic model_edge();
    if (!rst_n) foreach (m[i]) m[i] = '0;
    else if (we && wr != 0) m[wr] = wd;
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      rr1 = reg_idx_t'(i);
      rr2 = reg_idx_t'(31 - i);
      #1;
      chk({name, "_p1"}, rd1, 32'h0);
      chk({name, "_p2"}, rd2, 32'h0);
    end
  endtask

  initial begin
    vt[0]  = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd0,  32'h0,        32'h0};
    vt[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h12345678, 32'h0};
    vt[2]  = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd5,  32'h0,        32'h12345678};
    vt[3]  = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
    vt[4]  = '{1'b0, 5'd7,  32'hA5A5A5A5, 5'd0,  5'd7,  32'h0,        32'h0};
    vt[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd0,  32'h0,        32'h0};
    vt[6]  = '{1'b1, 5'd3,  32'h1,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vt[7]  = '{1'b1, 5'd3,  32'h2,        5'd3,  5'd3,  32'h1,        32'h1};
    vt[8]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd5,  32'h2,        32'h12345678};
    vt[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,  32'h0,        32'h0};
    vt[10] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'hCAFEF00D, 32'h0};

    rst_n = 1'b0; we = 1'b1; wr = 5'd9; wd = 32'h77;
    tick();
    rst_n = 1'b1; we = 1'b0;
    foreach (m[i]) m[i] = '0;
    sweep_zero("reset_sweep");

    for (int i = 0; i < 11; i++) begin
      we = vt[i].we; wr = vt[i].wr; wd = vt[i].wd;
      rr1 = vt[i].rr1; rr2 = vt[i].rr2;
      #1;
      chk($sformatf("vec%0d_rd1", i), rd1, vt[i].exp1);
      chk($sformatf("vec%0d_rd2", i), rd2, vt[i].exp2);
      model_edge();
      tick();
    end
    we = 1'b0; rr1 = 5'd3; #1;
    chk("same_cycle_after", rd1, 32'h2);

    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 40) != 0);
      we    = $urandom_range(0, 1) == 1;
      wr    = reg_idx_t'($urandom_range(0, 31));
      wd    = $urandom;
      rr1   = ($urandom_range(0, 3) == 0) ? wr : reg_idx_t'($urandom_range(0, 31));
      rr2   = reg_idx_t'($urandom_range(0, 31));
      #1;
      chk("rand_rd1", rd1, model_rd(rr1));
      chk("rand_rd2", rd2, model_rd(rr2));
      model_edge();
      tick();
    end
    rst_n = 1'b1;

    we = 1'b1; wd = 32'hFFFFFFFF;
    for (int i = 1; i < 32; i++) begin
      wr = reg_idx_t'(i);
      tick();
    end
    we = 1'b0; rr1 = 5'd4; rr2 = 5'd0; #1;
    chk("full_reg4", rd1, 32'hFFFFFFFF);
    chk("full_reg0", rd2, 32'h0);
    rst_n = 1'b0; we = 1'b1; wr = 5'd4; wd = 32'h55;
    tick();
    rst_n = 1'b1; we = 1'b0;
    sweep_zero("midreset_sweep");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
